// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the FIFO-fed UART transmitter: write port, FIFO status and serial line.
// The host drives through the master modport and the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          wr_en;
  logic [DATA_BITS-1:0]          wr_data;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          overflow;
  logic                          busy;
  logic                          tx;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow, busy, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow, busy, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO: programmable divisor, word width, parity and stop bits.
// Define UART_TX_BREAK_EN to add the brk input with line-break and mark-after-break states.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef UART_TX_BREAK_EN
  input  logic          brk,
`endif
  uart_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BREAK,
    MARK
`endif
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg, count_next;
  logic                 full_reg, empty_reg, overflow_reg;
  logic                 push, pop;

  state_t               state_reg, state_next;
  logic [BW-1:0]        baud_cnt_reg, baud_cnt_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg;
  logic                 tx_reg, tx_next;
  logic                 bit_end;
  logic                 frame_done;

  // full is sampled before any same-cycle pop, so a write into a full FIFO is always dropped
  assign push = bus.wr_en & ~full_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      full_reg     <= (count_next == CNT_FULL);
      empty_reg    <= (count_next == '0);
      overflow_reg <= bus.wr_en & full_reg;
    end
  end

  assign bit_end = (baud_cnt_reg == BAUD_LAST);

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    pop           = 1'b0;
    frame_done    = 1'b0;

    if (state_reg != IDLE)
      baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: frame_done = 1'b1;
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            if (PARITY != 0) begin
              state_next = PAR;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_next   = STOP;
          tx_next      = 1'b1;
          bit_cnt_next = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_reg == STOP_LAST)
            frame_done = 1'b1;
          else
            bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        baud_cnt_next = '0;
        if (!brk) begin
          state_next = MARK;
          tx_next    = 1'b1;
        end
      end
      MARK: begin
        if (bit_end)
          frame_done = 1'b1;
      end
`endif
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Shared decision point for IDLE and end of frame: break, next word with no gap, or idle
    if (frame_done) begin
      baud_cnt_next = '0;
`ifdef UART_TX_BREAK_EN
      if (brk) begin
        state_next = BREAK;
        tx_next    = 1'b0;
      end else
`endif
      if (!empty_reg) begin
        pop        = 1'b1;
        state_next = START;
        tx_next    = 1'b0;
      end else begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_reg       <= tx_next;
      if (pop) begin
        shift_reg <= mem[rd_ptr_reg];
        par_reg   <= (PARITY == 1) ? ~^mem[rd_ptr_reg] : ^mem[rd_ptr_reg];
      end else begin
        shift_reg <= shift_next;
      end
    end
  end

  assign bus.full     = full_reg;
  assign bus.empty    = empty_reg;
  assign bus.count    = count_reg;
  assign bus.overflow = overflow_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.tx       = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (8N1, 8E2, 8N1 with 4-deep FIFO), baud divisor 4.
// With UART_TX_BREAK_EN defined the break/mark sequence is exercised on the shallow-FIFO instance.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef UART_TX_BREAK_EN
  logic brk_a = 1'b0;
  logic brk_b = 1'b0;
  logic brk_c = 1'b0;
`endif

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if_c ();

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk),
    .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk_a),
`endif
    .bus(if_a)
  );

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk),
    .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk_b),
`endif
    .bus(if_b)
  );

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_c (
    .clk(clk),
    .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk_c),
`endif
    .bus(if_c)
  );

  int checks = 0;
  int passed = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic line(input int which);
    case (which)
      0:       return if_a.tx;
      1:       return if_b.tx;
      default: return if_c.tx;
    endcase
  endfunction

  // 8N1 receiver at divisor 4: locks on the first low sample, then samples mid-bit
  task automatic rx_frame(input int which, output logic [7:0] data, output logic stop);
    int n = 0;
    data = 8'h00;
    stop = 1'b0;
    while (line(which) !== 1'b0 && n < 300) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 300) begin
      $display("FAIL rx_start dut=%0d: tx=%b after 300 clocks, required 0", which, line(which));
      return;
    end
    passed++;
    repeat (2) tick;
    for (int k = 0; k < 8; k++) begin
      repeat (4) tick;
      data[k] = line(which);
    end
    repeat (4) tick;
    stop = line(which);
    $display("rx dut=%0d data=0x%02h stop=%b", which, data, stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    checks++; if (if_a.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", if_a.tx); else passed++;
    checks++; if (if_a.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if_a.busy); else passed++;
    checks++; if (if_a.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", if_a.empty); else passed++;
    checks++; if (if_a.full !== 1'b0) $display("FAIL reset_full: got %b want 0", if_a.full); else passed++;
    checks++; if (if_a.count !== 5'd0) $display("FAIL reset_count: got %0d want 0", if_a.count); else passed++;
    checks++; if (if_a.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", if_a.overflow); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      checks++;
      if ({if_a.tx, if_a.empty, if_a.busy, if_a.count} !== {1'b1, 1'b1, 1'b0, 5'd0})
        $display("FAIL idle_clk%0d: tx/empty/busy/count got %b/%b/%b/%0d want 1/1/0/0",
                 i, if_a.tx, if_a.empty, if_a.busy, if_a.count);
      else
        passed++;
    end
    $display("reset: 100 idle clocks observed");
  endtask

  task automatic test_single_frame;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    if_a.wr_data = 8'hA5;
    if_a.wr_en   = 1'b1;
    tick;
    if_a.wr_en = 1'b0;
    checks++; if (if_a.tx !== 1'b1) $display("FAIL single_tx_write_edge: got %b want 1", if_a.tx); else passed++;
    checks++; if (if_a.count !== 5'd1) $display("FAIL single_count_write_edge: got %0d want 1", if_a.count); else passed++;
    tick;
    checks++; if (if_a.tx !== 1'b0) $display("FAIL single_tx_fall: got %b want 0", if_a.tx); else passed++;
    checks++; if (if_a.busy !== 1'b1) $display("FAIL single_busy_start: got %b want 1", if_a.busy); else passed++;
    checks++; if (if_a.empty !== 1'b1) $display("FAIL single_empty_pop: got %b want 1", if_a.empty); else passed++;
    repeat (2) tick;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (if_a.tx !== exp_bits[k]) $display("FAIL single_bit%0d: got %b want %b", k, if_a.tx, exp_bits[k]);
      else passed++;
      if (k < 9) repeat (4) tick;
    end
    tick;
    checks++; if (if_a.busy !== 1'b1) $display("FAIL single_busy_clk39: got %b want 1", if_a.busy); else passed++;
    tick;
    checks++; if (if_a.busy !== 1'b0) $display("FAIL single_busy_clk40: got %b want 0", if_a.busy); else passed++;
    checks++; if (if_a.tx !== 1'b1) $display("FAIL single_tx_idle: got %b want 1", if_a.tx); else passed++;
    $display("single frame 0xA5 done");
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp_bits;
    logic        busy_gap;
    exp_bits = {2'b11, 1'b1, 8'h80, 1'b0, 2'b11, 1'b0, 8'h03, 1'b0};
    busy_gap = 1'b0;
    if_b.wr_data = 8'h03;
    if_b.wr_en   = 1'b1;
    tick;
    if_b.wr_data = 8'h80;
    tick;
    if_b.wr_en = 1'b0;
    checks++; if (if_b.tx !== 1'b0) $display("FAIL b2b_tx_fall: got %b want 0", if_b.tx); else passed++;
    checks++; if (if_b.count !== 5'd1) $display("FAIL b2b_count_push_pop: got %0d want 1", if_b.count); else passed++;
    repeat (2) begin
      tick;
      if (if_b.busy !== 1'b1) busy_gap = 1'b1;
    end
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (if_b.tx !== exp_bits[k]) $display("FAIL b2b_bit%0d: got %b want %b", k, if_b.tx, exp_bits[k]);
      else passed++;
      if (k < 23) begin
        repeat (4) begin
          tick;
          if (if_b.busy !== 1'b1) busy_gap = 1'b1;
        end
      end
    end
    tick;
    checks++; if (if_b.busy !== 1'b1 || busy_gap !== 1'b0)
      $display("FAIL b2b_busy_through_clk95: busy=%b gap=%b want 1/0", if_b.busy, busy_gap); else passed++;
    tick;
    checks++; if (if_b.busy !== 1'b0) $display("FAIL b2b_busy_clk96: got %b want 0", if_b.busy); else passed++;
    checks++; if (if_b.empty !== 1'b1) $display("FAIL b2b_empty_end: got %b want 1", if_b.empty); else passed++;
    $display("back-to-back 0x03,0x80 even parity 2 stop done");
  endtask

  task automatic test_full_overflow;
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h99};
    int         exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
    logic       exp_full [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] got [5];
    logic       stp [5];
    logic       stray;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if_c.wr_en   = 1'b1;
          if_c.wr_data = words[i];
          tick;
          checks++; if (if_c.count !== 3'(exp_cnt[i]))
            $display("FAIL fifo_count_w%0d: got %0d want %0d", i, if_c.count, exp_cnt[i]); else passed++;
          checks++; if (if_c.full !== exp_full[i])
            $display("FAIL fifo_full_w%0d: got %b want %b", i, if_c.full, exp_full[i]); else passed++;
          checks++; if (if_c.overflow !== exp_ovf[i])
            $display("FAIL fifo_ovf_w%0d: got %b want %b", i, if_c.overflow, exp_ovf[i]); else passed++;
        end
        if_c.wr_en = 1'b0;
        tick;
        checks++; if (if_c.overflow !== 1'b0)
          $display("FAIL fifo_ovf_one_cycle: got %b want 0", if_c.overflow); else passed++;
        checks++; if (if_c.count !== 3'd4)
          $display("FAIL fifo_count_after_drop: got %0d want 4", if_c.count); else passed++;
      end
      begin
        for (int j = 0; j < 5; j++) rx_frame(2, got[j], stp[j]);
      end
    join
    for (int j = 0; j < 5; j++) begin
      checks++; if (got[j] !== words[j] || stp[j] !== 1'b1)
        $display("FAIL fifo_frame%0d: got 0x%02h stop %b want 0x%02h stop 1", j, got[j], stp[j], words[j]);
      else passed++;
    end
    stray = 1'b0;
    repeat (60) begin
      tick;
      if (if_c.tx !== 1'b1) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) $display("FAIL fifo_dropped_word_sent: tx left idle=%b want 0", stray); else passed++;
    checks++; if (if_c.empty !== 1'b1) $display("FAIL fifo_empty_end: got %b want 1", if_c.empty); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    logic       s;
    if_a.wr_data = 8'h55;
    if_a.wr_en   = 1'b1;
    tick;
    if_a.wr_data = 8'h66;
    tick;
    if_a.wr_en = 1'b0;
    repeat (17) tick;
    checks++; if (if_a.count !== 5'd1) $display("FAIL midrst_count_before: got %0d want 1", if_a.count); else passed++;
    checks++; if (if_a.tx !== 1'b0) $display("FAIL midrst_data_bit3: got %b want 0", if_a.tx); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (if_a.tx !== 1'b1) $display("FAIL midrst_tx_async: got %b want 1", if_a.tx); else passed++;
    checks++; if (if_a.empty !== 1'b1 || if_a.count !== 5'd0)
      $display("FAIL midrst_fifo_cleared: empty=%b count=%0d want 1/0", if_a.empty, if_a.count); else passed++;
    checks++; if (if_a.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", if_a.busy); else passed++;
    repeat (2) tick;
    rst = 1'b0;
    repeat (3) tick;
    if_a.wr_data = 8'h0F;
    if_a.wr_en   = 1'b1;
    tick;
    if_a.wr_en = 1'b0;
    rx_frame(0, d, s);
    checks++; if (d !== 8'h0F || s !== 1'b1)
      $display("FAIL midrst_new_frame: got 0x%02h stop %b want 0x0f stop 1", d, s); else passed++;
    repeat (10) tick;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    logic bad;
    brk_c        = 1'b1;
    if_c.wr_data = 8'h3C;
    if_c.wr_en   = 1'b1;
    tick;
    if_c.wr_en = 1'b0;
    checks++; if (if_c.tx !== 1'b0 || if_c.busy !== 1'b1)
      $display("FAIL brk_enter: tx=%b busy=%b want 0/1", if_c.tx, if_c.busy); else passed++;
    bad = 1'b0;
    for (int i = 1; i < 20; i++) begin
      tick;
      if (if_c.tx !== 1'b0 || if_c.count !== 3'd1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL brk_hold_20: deviation=%b want 0", bad); else passed++;
    brk_c = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (if_c.tx !== 1'b1 || if_c.busy !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL brk_mark_4: deviation=%b want 0", bad); else passed++;
    tick;
    checks++; if (if_c.tx !== 1'b0 || if_c.count !== 3'd0)
      $display("FAIL brk_queued_start: tx=%b count=%0d want 0/0", if_c.tx, if_c.count); else passed++;
    $display("break 20 clocks then mark 4 clocks done");
    repeat (45) tick;
  endtask
`endif

  initial begin
    if_a.wr_en = 1'b0; if_a.wr_data = '0;
    if_b.wr_en = 1'b0; if_b.wr_data = '0;
    if_c.wr_en = 1'b0; if_c.wr_data = '0;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_full_overflow;
    test_reset_mid_frame;
`ifdef UART_TX_BREAK_EN
    test_break;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
